hazard_scoreboard: RTL and testbench

Parametrised hazard and redirect controller for the in-order RV32I pipeline. It generalises the fixed EX/MEM/MEM2/WB forwarding and load-use logic to NSTAGES forwarding sources. It adds a per-register latency scoreboard for multi-cycle producers (loads, mul/div), a timed flush sequencer for redirects, and stall-cycle/deadlock instrumentation. It sits beside ID, supplies the EX operand values, and drives the IFU stall and flush controls.

---
 rtl/hazard_scoreboard.sv | 183 ++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard and redirect controller that sits beside ID in the in-order RV32I
//   pipeline. It resolves EX operands from NSTAGES forwarding sources.
//   A per-register latency scoreboard holds back consumers of multi-cycle
//   producers such as loads and mul/div. A flush sequencer handles redirects.
//   The block also counts stall cycles and runs a deadlock watchdog.
//
// Ports
//   clock, reset             clock; synchronous active-low reset
//   id_*                     instruction in ID: sources, register-file read
//                            values, destination, producer latency
//   fwd_valid/wen/ready      per forwarding stage flags (0 = EX, youngest)
//   fwd_rd, fwd_data         packed per-stage destination index and result
//   redirect_req/pc          EX-resolved control transfer and its target
//   rs1_out, rs2_out         forwarded operands to EX
//   stall, issue, flush      IFU / ID pipeline control
//   dnpc, dnpc_valid         redirect target and strobe
//   stall_cycles             saturating count of stall cycles
//   deadlock_err             sticky watchdog flag

module hazard_scoreboard #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int NSTAGES   = 4,
    parameter int LATW      = 4,
    parameter int FLUSH_LEN = 2,
    parameter int WDOG      = 64,
    localparam int RW       = $clog2(NREG)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [RW-1:0]           id_rs1,
    input  logic [RW-1:0]           id_rs2,
    input  logic                    id_rs1_ren,
    input  logic                    id_rs2_ren,
    input  logic [XLEN-1:0]         id_rf_rs1,
    input  logic [XLEN-1:0]         id_rf_rs2,
    input  logic [RW-1:0]           id_rd,
    input  logic                    id_rd_wen,
    input  logic [LATW-1:0]         id_lat,
    input  logic [NSTAGES-1:0]      fwd_valid,
    input  logic [NSTAGES-1:0]      fwd_wen,
    input  logic [NSTAGES-1:0]      fwd_ready,
    input  logic [NSTAGES*RW-1:0]   fwd_rd,
    input  logic [NSTAGES*XLEN-1:0] fwd_data,
    input  logic                    redirect_req,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic [XLEN-1:0]         rs1_out,
    output logic [XLEN-1:0]         rs2_out,
    output logic                    stall,
    output logic                    issue,
    output logic                    flush,
    output logic [XLEN-1:0]         dnpc,
    output logic                    dnpc_valid,
    output logic [31:0]             stall_cycles,
    output logic                    deadlock_err
);

    // The counter array is sized to the full index space, so any RW-bit
    // source index is a legal lookup. Entries at NREG and above never load.
    localparam int NCNT = 1 << RW;
    localparam int FW   = $clog2(FLUSH_LEN + 1);
    localparam int WW   = $clog2(WDOG + 1);

    logic [LATW-1:0] cnt [NCNT];
    logic [FW-1:0]   flush_cnt;
    logic [WW-1:0]   run_cnt;
    logic [31:0]     stall_cnt;
    logic            deadlock_q;

    logic [RW-1:0]   src_idx [2];
    logic            src_ren [2];
    logic [XLEN-1:0] src_rf  [2];
    logic [XLEN-1:0] src_op  [2];
    logic            src_hz  [2];
    logic            src_hit [2];

    logic [LATW-1:0] rd_cur;
    logic [LATW-1:0] rd_dec;
    logic [LATW-1:0] rd_new;
    logic            sb_write;

    assign src_idx[0] = id_rs1;
    assign src_idx[1] = id_rs2;
    assign src_ren[0] = id_rs1_ren;
    assign src_ren[1] = id_rs2_ren;
    assign src_rf[0]  = id_rf_rs1;
    assign src_rf[1]  = id_rf_rs2;

    // A count of 1 is the last cycle of the countdown. In that cycle the
    // result has reached a forwarding stage, so the stage's ready flag
    // decides. Only counts above 1 block a consumer. A producer with
    // latency L therefore stalls consumers for L-1 cycles after issue.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_op[s]  = src_rf[s];
            src_hz[s]  = 1'b0;
            src_hit[s] = 1'b0;
            if (src_ren[s] && (src_idx[s] != '0)) begin
                for (int i = 0; i < NSTAGES; i++) begin
                    if (!src_hit[s] && fwd_valid[i] && fwd_wen[i] &&
                        (fwd_rd[i*RW +: RW] == src_idx[s])) begin
                        src_hit[s] = 1'b1;
                        if (fwd_ready[i]) begin
                            src_op[s] = fwd_data[i*XLEN +: XLEN];
                        end else begin
                            src_hz[s] = 1'b1;
                        end
                    end
                end
                if (cnt[src_idx[s]] > LATW'(1)) begin
                    src_hz[s] = 1'b1;
                end
            end
        end
    end

    assign rs1_out = src_op[0];
    assign rs2_out = src_op[1];

    // Flush takes priority over stall, so a redirecting cycle never stalls.
    assign flush      = reset & (redirect_req | (flush_cnt != '0));
    assign stall      = reset & id_valid & (src_hz[0] | src_hz[1]) & ~flush;
    assign issue      = reset & id_valid & ~stall & ~flush;
    assign dnpc       = redirect_pc;
    assign dnpc_valid = reset & redirect_req;

    assign stall_cycles = stall_cnt;
    assign deadlock_err = deadlock_q;

    // For a WAW hazard the later-ready writer defines the count. The decrement
    // saturates at zero.
    assign rd_cur   = cnt[id_rd];
    assign rd_dec   = (rd_cur != '0) ? (rd_cur - 1'b1) : '0;
    assign rd_new   = (id_lat > rd_dec) ? id_lat : rd_dec;
    assign sb_write = issue & id_rd_wen & (id_rd != '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int r = 0; r < NCNT; r++) begin
                cnt[r] <= '0;
            end
            flush_cnt  <= '0;
            run_cnt    <= '0;
            stall_cnt  <= '0;
            deadlock_q <= 1'b0;
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NCNT; r++) begin
                if (sb_write && (id_rd == RW'(r))) begin
                    cnt[r] <= rd_new;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end

            // The redirect cycle itself is the first flush cycle. The
            // counter covers the remaining FLUSH_LEN-1 cycles.
            if (redirect_req) begin
                flush_cnt <= FW'(FLUSH_LEN - 1);
            end else if (flush_cnt != '0) begin
                flush_cnt <= flush_cnt - 1'b1;
            end

            if (stall) begin
                if (stall_cnt != '1) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
                if (run_cnt != WW'(WDOG)) begin
                    run_cnt <= run_cnt + 1'b1;
                end
                // The flag sets on the same edge where the run reaches WDOG.
                if (run_cnt >= WW'(WDOG - 1)) begin
                    deadlock_q <= 1'b1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int NSTAGES   = 4;
    localparam int LATW      = 4;
    localparam int FLUSH_LEN = 2;
    localparam int WDOG      = 8;
    localparam int RW        = 5;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    id_valid;
    logic [RW-1:0]           id_rs1, id_rs2, id_rd;
    logic                    id_rs1_ren, id_rs2_ren, id_rd_wen;
    logic [XLEN-1:0]         id_rf_rs1, id_rf_rs2;
    logic [LATW-1:0]         id_lat;
    logic [NSTAGES-1:0]      fwd_valid, fwd_wen, fwd_ready;
    logic [NSTAGES*RW-1:0]   fwd_rd;
    logic [NSTAGES*XLEN-1:0] fwd_data;
    logic                    redirect_req;
    logic [XLEN-1:0]         redirect_pc;
    logic [XLEN-1:0]         rs1_out, rs2_out, dnpc;
    logic                    stall, issue, flush, dnpc_valid, deadlock_err;
    logic [31:0]             stall_cycles;

    always #5 clock = ~clock;

    hazard_scoreboard #(
        .XLEN(XLEN), .NREG(NREG), .NSTAGES(NSTAGES), .LATW(LATW),
        .FLUSH_LEN(FLUSH_LEN), .WDOG(WDOG)
    ) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
        .id_rf_rs1(id_rf_rs1), .id_rf_rs2(id_rf_rs2),
        .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_lat(id_lat),
        .fwd_valid(fwd_valid), .fwd_wen(fwd_wen), .fwd_ready(fwd_ready),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .redirect_req(redirect_req), .redirect_pc(redirect_pc),
        .rs1_out(rs1_out), .rs2_out(rs2_out),
        .stall(stall), .issue(issue), .flush(flush),
        .dnpc(dnpc), .dnpc_valid(dnpc_valid),
        .stall_cycles(stall_cycles), .deadlock_err(deadlock_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each register remembers the absolute cycle from which its
    // producer is forwardable. Flush remembers the last cycle it covers.
    int     ready_at [NREG];
    int     flush_until = -1;
    int     cyc = 0;
    longint m_stalls = 0;
    int     m_run = 0;
    logic   m_dl = 1'b0;

    initial for (int r = 0; r < NREG; r++) ready_at[r] = 0;

    function automatic void resolve(input logic [RW-1:0] rs, input logic ren,
                                    input logic [XLEN-1:0] rf,
                                    output logic [XLEN-1:0] op, output logic hz);
        logic found;
        op = rf;
        hz = 1'b0;
        found = 1'b0;
        if (ren && rs != 0) begin
            if (cyc < ready_at[rs]) hz = 1'b1;
            for (int i = 0; i < NSTAGES; i++) begin
                if (!found && fwd_valid[i] && fwd_wen[i] && fwd_rd[i*RW +: RW] == rs) begin
                    found = 1'b1;
                    if (fwd_ready[i]) op = fwd_data[i*XLEN +: XLEN];
                    else hz = 1'b1;
                end
            end
        end
    endfunction

    always @(negedge clock) begin
        logic [XLEN-1:0] e1, e2;
        logic h1, h2, e_flush, e_stall, e_issue, e_dv;
        int t;
        resolve(id_rs1, id_rs1_ren, id_rf_rs1, e1, h1);
        resolve(id_rs2, id_rs2_ren, id_rf_rs2, e2, h2);
        e_flush = reset && (redirect_req || cyc <= flush_until);
        e_stall = reset && id_valid && (h1 || h2) && !e_flush;
        e_issue = reset && id_valid && !e_stall && !e_flush;
        e_dv    = reset && redirect_req;
        if (!h1) chk("m_rs1_out", rs1_out, e1);
        if (!h2) chk("m_rs2_out", rs2_out, e2);
        chk("m_stall", 32'(stall), 32'(e_stall));
        chk("m_issue", 32'(issue), 32'(e_issue));
        chk("m_flush", 32'(flush), 32'(e_flush));
        chk("m_dnpc_valid", 32'(dnpc_valid), 32'(e_dv));
        if (e_dv) chk("m_dnpc", dnpc, redirect_pc);
        chk("m_stall_cycles", stall_cycles, 32'(m_stalls));
        chk("m_deadlock", 32'(deadlock_err), 32'(m_dl));
        if (!reset) begin
            for (int r = 0; r < NREG; r++) ready_at[r] = 0;
            flush_until = -1;
            m_stalls = 0;
            m_run = 0;
            m_dl = 1'b0;
        end else begin
            if (e_issue && id_rd_wen && id_rd != 0) begin
                t = cyc + int'(id_lat);
                if (t > ready_at[id_rd]) ready_at[id_rd] = t;
            end
            if (redirect_req) flush_until = cyc + FLUSH_LEN - 1;
            if (e_stall) begin
                if (m_stalls < 64'hFFFF_FFFF) m_stalls++;
                m_run++;
                if (m_run >= WDOG) m_dl = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        cyc++;
    end

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_ren = 0; id_rs2_ren = 0;
        id_rf_rs1 = 32'h1111_0001; id_rf_rs2 = 32'h2222_0002;
        id_rd = 0; id_rd_wen = 0; id_lat = 0;
        fwd_valid = 0; fwd_wen = 0; fwd_ready = 0; fwd_rd = 0; fwd_data = 0;
        redirect_req = 0; redirect_pc = 0;
    endtask

    task automatic set_stage(input int i, input logic v, input logic w, input logic r,
                             input logic [RW-1:0] rd, input logic [XLEN-1:0] d);
        fwd_valid[i] = v;
        fwd_wen[i]   = w;
        fwd_ready[i] = r;
        fwd_rd[i*RW +: RW]     = rd;
        fwd_data[i*XLEN +: XLEN] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 0;
        clr();
        id_valid = 1; id_rs1 = 9; id_rs1_ren = 1;
        set_stage(0, 1, 1, 0, 9, 0);
        redirect_req = 1; redirect_pc = 32'h100;
        next();
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_dnpc_valid", 32'(dnpc_valid), 0);
        chk("rst_issue", 32'(issue), 0);
        next();
        reset = 1;
        clr();

        // EX forwarding
        id_valid = 1; id_rs1 = 5; id_rs1_ren = 1; id_rf_rs1 = 32'hdead_0001;
        set_stage(0, 1, 1, 1, 5, 32'h1234);
        #1;
        chk("ex_fwd_data", rs1_out, 32'h1234);
        chk("ex_fwd_stall", 32'(stall), 0);
        chk("ex_fwd_issue", 32'(issue), 1);

        // youngest match wins
        next(); clr();
        id_valid = 1; id_rs2 = 7; id_rs2_ren = 1; id_rf_rs2 = 32'hdead_0002;
        set_stage(0, 1, 1, 1, 7, 32'hA);
        set_stage(2, 1, 1, 1, 7, 32'hB);
        #1;
        chk("prio_data", rs2_out, 32'hA);
        chk("prio_stall0", 32'(stall), 0);
        next();
        set_stage(0, 1, 1, 0, 7, 32'hA);
        #1;
        chk("prio_notready_stall", 32'(stall), 1);
        next();
        set_stage(0, 1, 0, 0, 7, 32'hA);
        #1;
        chk("prio_nowen_data", rs2_out, 32'hB);
        chk("prio_nowen_stall", 32'(stall), 0);

        // x0 and unread sources
        next(); clr();
        id_valid = 1; id_rs1 = 0; id_rs1_ren = 1; id_rf_rs1 = 0;
        id_rs2 = 6; id_rs2_ren = 0; id_rf_rs2 = 32'h66;
        set_stage(0, 1, 1, 0, 0, 32'hFFFF_FFFF);
        set_stage(1, 1, 1, 0, 6, 0);
        #1;
        chk("x0_stall", 32'(stall), 0);
        chk("x0_data", rs1_out, 0);
        chk("unread_data", rs2_out, 32'h66);

        // scoreboard: lw x3, latency 3
        next(); clr();
        id_valid = 1; id_rd = 3; id_rd_wen = 1; id_lat = 3;
        #1;
        chk("sb_issue", 32'(issue), 1);
        next();
        id_rd_wen = 0; id_rd = 0; id_lat = 0;
        id_rs1 = 3; id_rs1_ren = 1; id_rf_rs1 = 32'h3333_0000;
        #1;
        chk("sb_stall_t1", 32'(stall), 1);
        next();
        #1;
        chk("sb_stall_t2", 32'(stall), 1);
        next();
        set_stage(1, 1, 1, 1, 3, 32'h33);
        #1;
        chk("sb_release", 32'(stall), 0);
        chk("sb_fwd_data", rs1_out, 32'h33);

        // WAW: lat 3 then lat 1 keeps the later-ready count (2)
        next(); clr();
        id_valid = 1; id_rd = 3; id_rd_wen = 1; id_lat = 3;
        next();
        id_lat = 1;
        #1;
        chk("waw_issue", 32'(issue), 1);
        next();
        id_rd_wen = 0; id_rd = 0; id_lat = 0; id_rs1 = 3; id_rs1_ren = 1;
        #1;
        chk("waw_hold", 32'(stall), 1);
        next();
        #1;
        chk("waw_release", 32'(stall), 0);

        // latency sweep: consumer right behind producer stalls max(L-1,0)
        for (int lat = 0; lat < 6; lat++) begin
            next(); clr();
            id_valid = 1; id_rd = 10; id_rd_wen = 1; id_lat = LATW'(lat);
            next();
            id_rd_wen = 0; id_rd = 0; id_lat = 0; id_rs1 = 10; id_rs1_ren = 1;
            n = 0;
            repeat (lat + 2) begin
                #1;
                if (stall) n++;
                next();
            end
            chk($sformatf("lat_sweep_%0d", lat), 32'(n), 32'((lat > 1) ? lat - 1 : 0));
        end

        // redirect with a stalled consumer in ID
        next(); clr();
        id_valid = 1; id_rs1 = 9; id_rs1_ren = 1;
        set_stage(0, 1, 1, 0, 9, 0);
        redirect_req = 1; redirect_pc = 32'h8000_0040;
        #1;
        chk("rd_dnpc_valid", 32'(dnpc_valid), 1);
        chk("rd_dnpc", dnpc, 32'h8000_0040);
        chk("rd_flush0", 32'(flush), 1);
        chk("rd_stall_prio", 32'(stall), 0);
        chk("rd_issue", 32'(issue), 0);
        next();
        redirect_req = 0;
        #1;
        chk("rd_flush1", 32'(flush), 1);
        chk("rd_dnpc_pulse", 32'(dnpc_valid), 0);
        next();
        #1;
        chk("rd_flush_end", 32'(flush), 0);
        chk("rd_stall_back", 32'(stall), 1);
        next();
        redirect_req = 1; redirect_pc = 32'h8000_0040;
        next();
        redirect_pc = 32'h8000_0080;
        #1;
        chk("rd2_dnpc", dnpc, 32'h8000_0080);
        chk("rd2_dnpc_valid", 32'(dnpc_valid), 1);
        next();
        redirect_req = 0;
        #1;
        chk("rd2_flush_ext", 32'(flush), 1);
        next();
        #1;
        chk("rd2_flush_end", 32'(flush), 0);

        // watchdog
        next(); clr();
        reset = 0;
        next();
        reset = 1;
        #1;
        chk("wd_cnt_clr", stall_cycles, 0);
        chk("wd_err_clr", 32'(deadlock_err), 0);
        id_valid = 1; id_rs1 = 9; id_rs1_ren = 1;
        set_stage(0, 1, 1, 0, 9, 0);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("wd_stall", 32'(stall), 1);
            if (k == 7) begin
                chk("wd_cnt7", stall_cycles, 7);
                chk("wd_err7", 32'(deadlock_err), 0);
            end
            next();
        end
        chk("wd_cnt8", stall_cycles, 8);
        chk("wd_err8", 32'(deadlock_err), 1);
        set_stage(0, 1, 1, 1, 9, 32'h99);
        #1;
        chk("wd_released", 32'(stall), 0);
        next();
        #1;
        chk("wd_sticky", 32'(deadlock_err), 1);
        chk("wd_cnt_hold", stall_cycles, 8);

        // reset aborts a scoreboard countdown
        next(); clr();
        id_valid = 1; id_rd = 4; id_rd_wen = 1; id_lat = 5;
        next();
        id_rd_wen = 0; id_rd = 0; id_lat = 0; id_rs1 = 4; id_rs1_ren = 1;
        #1;
        chk("x4_busy", 32'(stall), 1);
        reset = 0;
        #1;
        chk("x4_rst_force", 32'(stall), 0);
        next();
        reset = 1;
        #1;
        chk("x4_after_rst", 32'(stall), 0);
        chk("rst_cnt_zero", stall_cycles, 0);
        chk("rst_err_zero", 32'(deadlock_err), 0);
        id_rs2 = 0; id_rs2_ren = 1; id_rf_rs2 = 0;
        set_stage(0, 1, 1, 0, 0, 32'h5);
        #1;
        chk("x0_after_rst", 32'(stall), 0);
        next();
        next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
